// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the op-code constants, the controller state type and the LUI shift amount.
package alu_pkg;

  localparam logic [4:0] OpAnd   = 5'h00;
  localparam logic [4:0] OpOr    = 5'h01;
  localparam logic [4:0] OpAdd   = 5'h02;
  localparam logic [4:0] OpXor   = 5'h03;
  localparam logic [4:0] OpSll   = 5'h04;
  localparam logic [4:0] OpSgt   = 5'h05;
  localparam logic [4:0] OpSub   = 5'h06;
  localparam logic [4:0] OpSlt   = 5'h07;
  localparam logic [4:0] OpSrl   = 5'h08;
  localparam logic [4:0] OpSra   = 5'h09;
  localparam logic [4:0] OpLui   = 5'h0A;
  localparam logic [4:0] OpNor   = 5'h0C;
  localparam logic [4:0] OpMult  = 5'h10;
  localparam logic [4:0] OpMultu = 5'h11;
  localparam logic [4:0] OpDiv   = 5'h12;
  localparam logic [4:0] OpDivu  = 5'h13;
  localparam logic [4:0] OpMfhi  = 5'h14;
  localparam logic [4:0] OpMflo  = 5'h15;
  localparam logic [4:0] OpMthi  = 5'h16;
  localparam logic [4:0] OpMtlo  = 5'h17;

  // LUI moves the immediate into the upper half; 16 for the classic 32-bit datapath.
  localparam int unsigned LuiShift32 = 16;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } alu_state_e;

  function automatic int unsigned lui_shift(input int unsigned width);
    return (width == 32) ? LuiShift32 : width / 2;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply / divide engine, one bit per clock.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load operands and begin (only pulsed while the engine is idle)
//   is_div, is_signed   operation selection latched on start
//   a, b                operands
//   done                high during the cycle of the last iteration; hi/lo/dbz valid then
//   hi, lo              final HI/LO values (remainder/quotient or product halves)
//   dbz                 divide by zero flag
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam logic [SHW-1:0] LastIter = SHW'(WIDTH - 1);

  logic             busy_q;
  logic [SHW-1:0]   cnt_q;
  logic             div_q, neg_q, a_neg_q, dbz_q;
  logic [WIDTH-1:0] a_q, mb_q, rem_q, quo_q;
  logic [WIDTH-1:0] rem_d, quo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Work on magnitudes; the sign is restored once at the end.
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign ma    = a_neg ? -a : a;
  assign mb    = b_neg ? -b : b;

  // One iteration. Multiply: rem_q holds the running upper half, quo_q the multiplier
  // shifting out LSB first. Divide: {rem_q, quo_q} shifts left, quotient bits enter quo_q.
  always_comb begin
    mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mb_q} : '0);
    trial   = {rem_q, quo_q[WIDTH-1]};
    rem_d   = rem_q;
    quo_d   = quo_q;
    if (div_q) begin
      if (trial >= {1'b0, mb_q}) begin
        rem_d = trial[WIDTH-1:0] - mb_q;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_d = mul_sum[WIDTH:1];
      quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
    end
  end

  // Results are taken from the last iteration's next-state values so the controller
  // can capture them on the same edge that completes the final iteration.
  always_comb begin
    prod     = {rem_d, quo_d};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -quo_d : quo_d;
    rem_fix  = a_neg_q ? -rem_d : rem_d;
    if (!div_q) begin
      hi = prod_fix[2*WIDTH-1:WIDTH];
      lo = prod_fix[WIDTH-1:0];
    end else if (dbz_q) begin
      hi = a_q;
      lo = '1;
    end else begin
      // most-negative / -1 wraps naturally: quotient magnitude 2^(W-1) negates to itself
      hi = rem_fix;
      lo = quo_fix;
    end
  end

  assign done = busy_q && (cnt_q == LastIter);
  assign dbz  = div_q & dbz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      a_q     <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else if (start) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      div_q   <= is_div;
      neg_q   <= a_neg ^ b_neg;
      a_neg_q <= a_neg;
      dbz_q   <= is_div && (b == '0);
      a_q     <= a;
      mb_q    <= mb;
      rem_q   <= '0;
      quo_q   <= ma;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q == LastIter) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + SHW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential MIPS-style ALU with HI/LO registers.
// Single-cycle ops complete one cycle after acceptance; MULT/MULTU/DIV/DIVU run on the
// iterative engine and complete WIDTH+1 cycles after acceptance.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; ready only while idle
//   op, a, b, shamt     operation code and operands
//   out_valid           one-cycle result strobe
//   result, zero        result and result==0 flag, held until the next strobe
//   div_by_zero         set by a divide with b == 0
//   hi, lo              architectural HI/LO registers
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned LuiSh = lui_shift(WIDTH);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             zero_q, dbz_q;

  logic             accept, is_mul, is_div, md_signed, md_start;
  logic             md_done, md_dbz;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] alu_res;
  logic             alu_def;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (op == OpMult) || (op == OpMultu);
  assign is_div    = (op == OpDiv) || (op == OpDivu);
  assign md_signed = (op == OpMult) || (op == OpDiv);
  assign md_start  = accept & (is_mul | is_div);

  alu_muldiv_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .is_div    (is_div),
    .is_signed (md_signed),
    .a         (a),
    .b         (b),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo),
    .dbz       (md_dbz)
  );

  // Single-cycle datapath; alu_def clears for undefined codes so zero stays low.
  always_comb begin
    alu_res = '0;
    alu_def = 1'b1;
    case (op)
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpAdd:  alu_res = a + b;
      OpXor:  alu_res = a ^ b;
      OpSll:  alu_res = b << shamt;
      OpSgt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) > $signed(b)};
      OpSub:  alu_res = a - b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OpSrl:  alu_res = b >> shamt;
      OpSra:  alu_res = $signed(b) >>> shamt;
      OpLui:  alu_res = b << LuiSh;
      OpNor:  alu_res = ~(a | b);
      OpMfhi: alu_res = hi_q;
      OpMflo: alu_res = lo_q;
      OpMthi: alu_res = a;
      OpMtlo: alu_res = a;
      default: alu_def = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= StMul;
            end else if (is_div) begin
              state_q <= StDiv;
            end else begin
              state_q  <= StDone;
              result_q <= alu_res;
              zero_q   <= alu_def && (alu_res == '0);
              dbz_q    <= 1'b0;
              if (op == OpMthi) hi_q <= a;
              if (op == OpMtlo) lo_q <= a;
            end
          end
        end
        StMul, StDiv: begin
          if (md_done) begin
            state_q  <= StDone;
            hi_q     <= md_hi;
            lo_q     <= md_lo;
            result_q <= md_lo;
            zero_q   <= (md_lo == '0);
            dbz_q    <= md_dbz;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 32-bit instance for the main vectors, 16-bit instance
// for the narrow multiply case.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, zero, div_by_zero;
  logic [4:0]  op;
  logic [31:0] a, b, result, hi, lo;
  logic [4:0]  shamt;

  logic        in_valid16, in_ready16, out_valid16, zero16, dbz16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, result16, hi16, lo16;
  logic [3:0]  shamt16;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid16),
    .in_ready    (in_ready16),
    .op          (op16),
    .a           (a16),
    .b           (b16),
    .shamt       (shamt16),
    .out_valid   (out_valid16),
    .result      (result16),
    .zero        (zero16),
    .div_by_zero (dbz16),
    .hi          (hi16),
    .lo          (lo16)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; leaves the bench at the negedge
  // of the result cycle.
  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] s, input int exp_lat);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic run_alu(input string tag, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] s,
                         input logic [31:0] exp_res, input logic exp_zero);
    do_op(tag, o, x, y, s, 1);
    check_eq({tag, "_res"}, result, exp_res);
    check_eq({tag, "_zero"}, zero, exp_zero);
  endtask

  task automatic run_md(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    do_op(tag, o, x, y, 5'd0, 33);
    check_eq({tag, "_hi"}, hi, exp_hi);
    check_eq({tag, "_lo"}, lo, exp_lo);
    check_eq({tag, "_res"}, result, exp_lo);
    check_eq({tag, "_zero"}, zero, exp_lo == 32'd0);
    check_eq({tag, "_dbz"}, div_by_zero, exp_dbz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy;
    int seen_ov;
    logic [31:0] lo_at_ov;
    int lat16;

    clk = 0; rst_n = 0;
    in_valid = 0; op = '0; a = '0; b = '0; shamt = '0;
    in_valid16 = 0; op16 = '0; a16 = '0; b16 = '0; shamt16 = '0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1;

    // single-cycle ops
    run_alu("add_ovf", 5'h02, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0);
    run_alu("sub_eq",  5'h06, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1);
    run_alu("and",     5'h00, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0);
    run_alu("or",      5'h01, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0, 1'b0);
    run_alu("xor",     5'h03, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_0FF0, 1'b0);
    run_alu("nor",     5'h0C, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    run_alu("sll",     5'h04, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 1'b0);
    run_alu("srl",     5'h08, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    run_alu("sra",     5'h09, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    run_alu("slt",     5'h07, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0);
    run_alu("sgt",     5'h05, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);
    run_alu("lui",     5'h0A, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);

    // multiply / divide
    run_md("mult",   5'h10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_md("multu",  5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run_md("div",    5'h12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("divu0",  5'h13, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    run_md("divovf", 5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_alu("mfhi0", 5'h14, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1);
    run_md("divu",   5'h13, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // HI/LO moves and undefined op
    run_alu("mthi", 5'h16, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'hDEAD_BEEF, 1'b0);
    check_eq("mthi_hi", hi, 32'hDEAD_BEEF);
    check_eq("mthi_lo", lo, 32'd14);
    run_alu("mtlo", 5'h17, 32'd5, 32'h0, 5'd0, 32'd5, 1'b0);
    run_alu("mflo", 5'h15, 32'h0, 32'h0, 5'd0, 32'd5, 1'b0);
    run_alu("undef", 5'h1F, 32'h1, 32'h2, 5'd0, 32'h0, 1'b0);
    check_eq("undef_hi", hi, 32'hDEAD_BEEF);
    check_eq("undef_lo", lo, 32'd5);
    run_alu("mfhi", 5'h14, 32'h0, 32'h0, 5'd0, 32'hDEAD_BEEF, 1'b0);

    // Request held through a busy MULT: the ADD must wait until the cycle after out_valid.
    @(negedge clk);
    op = 5'h10; a = 32'd2; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 5'h02; a = 32'd1; b = 32'd2;
    busy = 0; seen_ov = 0; lo_at_ov = '0;
    while (!in_ready && busy < 100) begin
      if (out_valid) begin
        seen_ov++;
        lo_at_ov = result;
      end
      busy++;
      @(negedge clk);
    end
    check_eq("busy_cycles", busy, 33);
    check_eq("busy_ov_count", seen_ov, 1);
    check_eq("busy_mult_res", lo_at_ov, 32'd6);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("held_add_ov", out_valid, 1);
    check_eq("held_add_res", result, 32'd3);

    // Reset in the middle of a DIVU.
    @(negedge clk);
    op = 5'h13; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    @(negedge clk);
    rst_n = 1;
    seen_ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_ov++;
    end
    check_eq("abort_no_ov", seen_ov, 0);
    check_eq("abort_hi_after", hi, 0);
    check_eq("abort_lo_after", lo, 0);

    // 16-bit MULT -3 * 7
    @(negedge clk);
    op16 = 5'h10; a16 = 16'hFFFD; b16 = 16'd7; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    lat16 = 1;
    while (!out_valid16 && lat16 < 200) begin
      @(negedge clk);
      lat16++;
    end
    check_eq("w16_lat", lat16, 17);
    check_eq("w16_hi", hi16, 16'hFFFF);
    check_eq("w16_lo", lo16, 16'hFFEB);
    check_eq("w16_res", result16, 16'hFFEB);
    check_eq("w16_dbz", dbz16, 0);
    check_eq("w16_zero", zero16, 0);
    check_eq("w16_ready", in_ready16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port op  input  5  operation code (REQ-012).
REQ-008 SHALL have port a  input  WIDTH  signed operand A (rs).
REQ-009 SHALL have port b  input  WIDTH  signed operand B (rt/immediate mux output).
REQ-010 SHALL have port shamt  input  SHW  shift amount.
REQ-011 SHALL have ports out_valid  output  1  result strobe; result  output  WIDTH; zero  output  1; div_by_zero  output  1; hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-012 op codes: 0x00 AND, 0x01 OR, 0x02 ADD, 0x03 XOR, 0x04 SLL, 0x05 SGT, 0x06 SUB, 0x07 SLT, 0x08 SRL, 0x09 SRA, 0x0A LUI (b << 16, or b << WIDTH/2 when WIDTH != 32), 0x0C NOR, 0x10 MULT, 0x11 MULTU, 0x12 DIV, 0x13 DIVU, 0x14 MFHI, 0x15 MFLO, 0x16 MTHI (hi<=a), 0x17 MTLO (lo<=a).
REQ-013 Request accepted on a rising edge where in_valid && in_ready; in_ready SHALL be 1 only in state IDLE.
REQ-014 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on accepted MULT/MULTU, IDLE->DIV on accepted DIV/DIVU, IDLE->DONE on any other accepted op, MUL/DIV->DONE after exactly WIDTH iteration cycles, DONE->IDLE unconditionally.
REQ-015 out_valid SHALL be 1 for exactly one cycle (state DONE); result/zero/div_by_zero valid only then and held until next DONE.
REQ-016 Latency: single-cycle ops out_valid 1 cycle after acceptance; MULT/MULTU/DIV/DIVU out_valid WIDTH+1 cycles after acceptance.
REQ-017 Arithmetic wraps modulo 2^WIDTH; no overflow trap; SLT/SGT signed compare, result 0 or 1.
REQ-018 MULT/MULTU: iterative shift-add, 2*WIDTH-bit product, hi<=upper half, lo<=lower half; signed form uses operand magnitudes and negates product when signs differ.
REQ-019 DIV/DIVU: iterative restoring division, lo<=quotient, hi<=remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-020 DIV with a = most-negative, b = -1: lo<=a, hi<=0, div_by_zero=0.
REQ-021 Divide by zero: hi<=a, lo<=all ones, div_by_zero=1, latency unchanged.
REQ-022 For mul/div ops result SHALL equal new lo; MFHI/MFLO result = hi/lo; MTHI/MTLO result = a.
REQ-023 zero SHALL be 1 iff result == 0, for every op.
REQ-024 Undefined op codes: result 0, zero 0, hi/lo unchanged, latency 1.
REQ-025 hi/lo SHALL change only on the cycle entering DONE for ops that write them.
REQ-026 in_valid while in_ready=0 SHALL be ignored; requester holds it.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, result 0, zero 0, div_by_zero 0, hi 0, lo 0, iteration counter 0.
REQ-028 Reset during MUL/DIV SHALL abort the operation with no partial hi/lo update and no out_valid.

Structure
REQ-029 Package alu_pkg SHALL hold op-code constants, FSM state typedef, and LUI shift constant.
REQ-030 Iterative multiply/divide datapath SHALL be sub-module alu_muldiv_seq (start, is_div, is_signed, a, b -> done, hi, lo, dbz); combinational ops stay in alu_seq.

Verification
REQ-031 ADD a=0x7FFFFFFF b=1 -> one cycle later out_valid, result 0x80000000, zero 0; SUB a=5 b=5 -> result 0, zero 1.
REQ-032 MULT a=-3 b=7 -> out_valid at cycle 33, hi 0xFFFFFFFF, lo 0xFFFFFFEB; MULTU a=b=0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001.
REQ-033 DIV a=-7 b=2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU a=7 b=0 -> lo 0xFFFFFFFF, hi 7, div_by_zero 1.
REQ-034 DIV a=0x80000000 b=-1 -> lo 0x80000000, hi 0; then MFHI -> result 0, zero 1.
REQ-035 in_valid held during MULT busy -> in_ready 0 for 33 cycles, second op accepted cycle after out_valid.
REQ-036 rst_n low at iteration 10 of DIVU -> outputs reset immediately, no out_valid, hi/lo 0; WIDTH=16 rerun of REQ-032 MULT -> out_valid cycle 17, hi 0xFFFF, lo 0xFFEB.
